fetch_ctrl: RTL

Instruction-fetch controller that sits directly around the PC register in the CPU-54 datapath. It reads the current PC, runs the instruction-memory request/ready handshake, and holds the fetched word in an instruction register for decode under a valid/ready handshake. It computes the next PC (sequential, branch, jump, eret, exception, flush) and drives the PC register's data and write-enable inputs with a one-cycle pulse.

---
 rtl/fetch_ctrl.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/fetch_ctrl.sv
// ---------------------------------------------------------------------------
// fetch_ctrl: instruction-fetch controller wrapped around the CPU-54 PC register.
//
// Reads the current PC and runs the imem request/ready handshake. It holds the
// fetched word in an instruction register, which decode takes under a
// valid/ready handshake. It then works out the next PC (sequential, branch,
// jump, eret, exception or flush) and pulses the PC register write enable for
// one cycle.
//
// Every output is registered. State flow: REQ -> HOLD -> UPD -> REQ. A flush
// while a fetch is outstanding detours through DRAIN.
//
// Ports
//   IF_clk, IF_rst        clock, synchronous active-high reset
//   pc_cur                current PC from the PC register
//   pc_next, pc_wena      PC register data / one-cycle write enable
//   imem_req, imem_addr   fetch request and word address (relative to RESET_PC)
//   imem_ready, imem_rdata  fetch completion and instruction word
//   ir_valid, ir_ready    decode handshake
//   ir_data, ir_pc        held instruction and its PC
//   exc_req               redirect to EXC_VECTOR
//   eret_req, epc_in      redirect to epc_in
//   jmp_req, jmp_target   redirect to jmp_target
//   br_req, br_offset     taken branch, signed word offset
//   flush_req, flush_target  redirect from a later stage, highest priority
// ---------------------------------------------------------------------------
module fetch_ctrl #(
   parameter logic [31:0] RESET_PC   = 32'h0040_0000,
   parameter logic [31:0] EXC_VECTOR = 32'h0040_0004,
   parameter int unsigned ADDR_W     = 11
) (
   input  logic              IF_clk,
   input  logic              IF_rst,
   input  logic [31:0]       pc_cur,
   output logic [31:0]       pc_next,
   output logic              pc_wena,
   output logic              imem_req,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic              imem_ready,
   input  logic [31:0]       imem_rdata,
   output logic              ir_valid,
   input  logic              ir_ready,
   output logic [31:0]       ir_data,
   output logic [31:0]       ir_pc,
   input  logic              exc_req,
   input  logic              eret_req,
   input  logic [31:0]       epc_in,
   input  logic              jmp_req,
   input  logic [31:0]       jmp_target,
   input  logic              br_req,
   input  logic [15:0]       br_offset,
   input  logic              flush_req,
   input  logic [31:0]       flush_target
);

   typedef enum logic [1:0] {StReq, StHold, StUpd, StDrain} state_t;

   state_t            state;
   logic [ADDR_W-1:0] fetch_addr;
   logic [31:0]       seq_pc;
   logic [31:0]       br_pc;
   logic [31:0]       redirect_pc;

   always_comb begin
      fetch_addr = ADDR_W'((pc_cur - RESET_PC) >> 2);
      seq_pc     = ir_pc + 32'd4;
      br_pc      = seq_pc + {{14{br_offset[15]}}, br_offset, 2'b00};
      if (exc_req) begin
         redirect_pc = EXC_VECTOR;
      end else if (eret_req) begin
         redirect_pc = epc_in;
      end else if (jmp_req) begin
         redirect_pc = jmp_target;
      end else if (br_req) begin
         redirect_pc = br_pc;
      end else begin
         redirect_pc = seq_pc;
      end
   end

   always_ff @(posedge IF_clk) begin
      if (IF_rst) begin
         state     <= StReq;
         imem_req  <= 1'b0;
         imem_addr <= '0;
         ir_valid  <= 1'b0;
         ir_data   <= 32'd0;
         ir_pc     <= RESET_PC;
         pc_next   <= RESET_PC;
         pc_wena   <= 1'b0;
      end else begin
         unique case (state)
            StReq: begin
               if (!imem_req) begin
                  // First cycle after reset: no fetch is outstanding yet, and a
                  // late imem_ready from before the reset is ignored.
                  if (flush_req) begin
                     pc_next <= flush_target;
                     pc_wena <= 1'b1;
                     state   <= StUpd;
                  end else begin
                     imem_req  <= 1'b1;
                     imem_addr <= fetch_addr;
                  end
               end else if (flush_req) begin
                  pc_next <= flush_target;
                  if (imem_ready) begin
                     imem_req <= 1'b0;
                     pc_wena  <= 1'b1;
                     state    <= StUpd;
                  end else begin
                     // The request cannot be withdrawn, so wait it out.
                     state <= StDrain;
                  end
               end else if (imem_ready) begin
                  ir_data  <= imem_rdata;
                  ir_pc    <= pc_cur;
                  ir_valid <= 1'b1;
                  imem_req <= 1'b0;
                  state    <= StHold;
               end
            end
            StHold: begin
               // A flush beats an accept in the same cycle.
               if (flush_req) begin
                  pc_next  <= flush_target;
                  ir_valid <= 1'b0;
                  pc_wena  <= 1'b1;
                  state    <= StUpd;
               end else if (ir_ready) begin
                  pc_next  <= redirect_pc;
                  ir_valid <= 1'b0;
                  pc_wena  <= 1'b1;
                  state    <= StUpd;
               end
            end
            StUpd: begin
               if (flush_req) begin
                  // Extend the write pulse so the flush target lands too.
                  pc_next <= flush_target;
               end else begin
                  // pc_cur was written on the falling edge of this cycle.
                  pc_wena   <= 1'b0;
                  imem_req  <= 1'b1;
                  imem_addr <= fetch_addr;
                  state     <= StReq;
               end
            end
            StDrain: begin
               if (flush_req) begin
                  pc_next <= flush_target;
               end else if (imem_ready) begin
                  imem_req <= 1'b0;
                  pc_wena  <= 1'b1;
                  state    <= StUpd;
               end
            end
         endcase
      end
   end

endmodule
